// File: rtl/commit_stage.sv
// commit_stage: retire end of the ROB commit bus.
// One instruction retires per cycle. Retiring updates the architectural regfile,
// releases stores and updates the BTB and gshare predictor. A committed
// misprediction sends a one-cycle cpuReset/priorCommit pulse back to the ROB,
// restores the register-status snapshot and holds a fetch redirect for
// FLUSH_CYCLES cycles. Commits that arrive during that window are dropped.
module commit_stage #(
  parameter int WIDTH        = 31,
  parameter int CONTROL      = 5,
  parameter int INDEX        = 7,
  parameter int ROB          = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic               clk,
  input  logic               globalResetN,
  input  logic               validCommit,
  input  logic [ROB:0]       commitRob,
  input  logic [WIDTH:0]     result,
  input  logic [WIDTH:0]     destCommit,
  input  logic [3:0]         commitInfo,
  input  logic [CONTROL:0]   controlFlow,
  input  logic [WIDTH:0]     targetAddress,
  input  logic [WIDTH:0]     oldPC,
  input  logic [WIDTH:0]     statusSnap,
  input  logic [INDEX:0]     previousIndex,
  output logic               rfWrite,
  output logic [4:0]         rfAddr,
  output logic [WIDTH:0]     rfData,
  output logic               memWrite,
  output logic [WIDTH:0]     memAddr,
  output logic [WIDTH:0]     memData,
  output logic               btbWrite,
  output logic [WIDTH:0]     btbPC,
  output logic [WIDTH:0]     btbTarget,
  output logic [1:0]         btbState,
  output logic               phtUpdate,
  output logic [INDEX:0]     phtIndex,
  output logic               phtTaken,
  output logic               cpuReset,
  output logic               priorCommit,
  output logic [ROB:0]       reset_ptr,
  output logic               statusRestore,
  output logic [WIDTH:0]     statusOut,
  output logic               redirect,
  output logic [WIDTH:0]     redirectPC,
  output logic [31:0]        retired
);

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

  typedef enum logic [1:0] {RUN, RECOVER, FLUSH} state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  // controlFlow fields
  logic       is_control, write_btb, taken, mispredict;
  logic [1:0] next_state;

  // commitInfo fields
  logic reg_write, mem_write, jump, branch;

  assign is_control = controlFlow[5];
  assign next_state = controlFlow[4:3];
  assign write_btb  = controlFlow[2];
  assign taken      = controlFlow[1];
  // A reset bit without isControl is malformed and retires as a normal commit.
  assign mispredict = controlFlow[0] & is_control;

  assign {reg_write, mem_write, jump, branch} = commitInfo;

  // Retire FSM with registered outputs; strobes default low every cycle.
  always_ff @(posedge clk or negedge globalResetN) begin
    if (!globalResetN) begin
      state         <= RUN;
      cnt           <= '0;
      rfWrite       <= 1'b0;
      rfAddr        <= '0;
      rfData        <= '0;
      memWrite      <= 1'b0;
      memAddr       <= '0;
      memData       <= '0;
      btbWrite      <= 1'b0;
      btbPC         <= '0;
      btbTarget     <= '0;
      btbState      <= '0;
      phtUpdate     <= 1'b0;
      phtIndex      <= '0;
      phtTaken      <= 1'b0;
      cpuReset      <= 1'b0;
      priorCommit   <= 1'b0;
      reset_ptr     <= '0;
      statusRestore <= 1'b0;
      statusOut     <= '0;
      redirect      <= 1'b0;
      redirectPC    <= '0;
      retired       <= '0;
    end else begin
      rfWrite       <= 1'b0;
      memWrite      <= 1'b0;
      btbWrite      <= 1'b0;
      phtUpdate     <= 1'b0;
      cpuReset      <= 1'b0;
      priorCommit   <= 1'b0;
      statusRestore <= 1'b0;
      case (state)
        RUN: begin
          if (validCommit) begin
            retired   <= retired + 32'd1;
            // x0 is hardwired, so writes to it are dropped here
            rfWrite   <= (reg_write | jump) && (destCommit[4:0] != 5'd0);
            rfAddr    <= destCommit[4:0];
            rfData    <= result;
            memWrite  <= mem_write;
            memAddr   <= destCommit;
            memData   <= result;
            btbWrite  <= is_control & write_btb;
            btbPC     <= oldPC;
            btbTarget <= targetAddress;
            btbState  <= next_state;
            phtUpdate <= branch;
            phtIndex  <= previousIndex;
            phtTaken  <= taken;
            if (mispredict) begin
              cpuReset      <= 1'b1;
              priorCommit   <= 1'b1;
              reset_ptr     <= commitRob;
              statusRestore <= 1'b1;
              statusOut     <= statusSnap;
              redirect      <= 1'b1;
              redirectPC    <= targetAddress;
              state         <= RECOVER;
            end
          end
        end
        // The ROB re-presents its head entry here; it is ignored and the
        // redirect is held so that it stays high for FLUSH_CYCLES cycles in total.
        RECOVER: begin
          if (FLUSH_CYCLES <= 1) begin
            redirect <= 1'b0;
            state    <= RUN;
          end else begin
            cnt   <= CW'(FLUSH_CYCLES - 1);
            state <= FLUSH;
          end
        end
        // Count down the remaining redirect cycles, then resume retiring.
        FLUSH: begin
          cnt <= cnt - 1'b1;
          if (cnt <= CW'(1)) begin
            cnt      <= '0;
            redirect <= 1'b0;
            state    <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_commit_stage.sv
// Randomised and directed bench for commit_stage with an expected-output model.
module tb_commit_stage;

  localparam int FLUSH_CYCLES = 2;

  logic        clk = 1'b0;
  logic        globalResetN;
  logic        validCommit;
  logic [2:0]  commitRob;
  logic [31:0] result, destCommit, targetAddress, oldPC, statusSnap;
  logic [3:0]  commitInfo;
  logic [5:0]  controlFlow;
  logic [7:0]  previousIndex;

  logic        rfWrite, memWrite, btbWrite, phtUpdate, phtTaken;
  logic        cpuReset, priorCommit, statusRestore, redirect;
  logic [4:0]  rfAddr;
  logic [31:0] rfData, memAddr, memData, btbPC, btbTarget, statusOut, redirectPC, retired;
  logic [1:0]  btbState;
  logic [7:0]  phtIndex;
  logic [2:0]  reset_ptr;

  int total = 0;
  int bad   = 0;

  commit_stage #(.FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk(clk), .globalResetN(globalResetN), .validCommit(validCommit),
    .commitRob(commitRob), .result(result), .destCommit(destCommit),
    .commitInfo(commitInfo), .controlFlow(controlFlow),
    .targetAddress(targetAddress), .oldPC(oldPC), .statusSnap(statusSnap),
    .previousIndex(previousIndex),
    .rfWrite(rfWrite), .rfAddr(rfAddr), .rfData(rfData),
    .memWrite(memWrite), .memAddr(memAddr), .memData(memData),
    .btbWrite(btbWrite), .btbPC(btbPC), .btbTarget(btbTarget), .btbState(btbState),
    .phtUpdate(phtUpdate), .phtIndex(phtIndex), .phtTaken(phtTaken),
    .cpuReset(cpuReset), .priorCommit(priorCommit), .reset_ptr(reset_ptr),
    .statusRestore(statusRestore), .statusOut(statusOut),
    .redirect(redirect), .redirectPC(redirectPC), .retired(retired)
  );

  always #5 clk = ~clk;

  // Expected outputs. "blocked" counts the input cycles still swallowed by a recovery.
  logic        m_rf, m_mw, m_btb, m_pht, m_ptaken, m_cpu, m_sr, m_redir;
  logic [4:0]  m_rfa;
  logic [31:0] m_rfd, m_ma, m_md, m_bpc, m_btgt, m_sout, m_rpc, m_ret;
  logic [1:0]  m_bst;
  logic [7:0]  m_pidx;
  logic [2:0]  m_rptr;
  int          blocked;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    {m_rf, m_mw, m_btb, m_pht, m_ptaken, m_cpu, m_sr, m_redir} = '0;
    m_rfa = '0; m_rfd = '0; m_ma = '0; m_md = '0; m_bpc = '0; m_btgt = '0;
    m_sout = '0; m_rpc = '0; m_ret = '0; m_bst = '0; m_pidx = '0; m_rptr = '0;
    blocked = 0;
  endtask

  // What one clock edge does to the outputs, given the inputs being presented.
  task automatic model_step();
    {m_rf, m_mw, m_btb, m_pht, m_cpu, m_sr} = '0;
    if (blocked > 0) begin
      blocked--;
      if (blocked == 0) m_redir = 1'b0;
    end else if (validCommit) begin
      m_ret    = m_ret + 1;
      m_rf     = (commitInfo[3] || commitInfo[1]) && destCommit[4:0] != 0;
      m_rfa    = destCommit[4:0];
      m_rfd    = result;
      m_mw     = commitInfo[2];
      m_ma     = destCommit;
      m_md     = result;
      m_btb    = controlFlow[5] && controlFlow[2];
      m_bpc    = oldPC;
      m_btgt   = targetAddress;
      m_bst    = controlFlow[4:3];
      m_pht    = commitInfo[0];
      m_pidx   = previousIndex;
      m_ptaken = controlFlow[1];
      if (controlFlow[5] && controlFlow[0]) begin
        m_cpu   = 1'b1;
        m_sr    = 1'b1;
        m_rptr  = commitRob;
        m_sout  = statusSnap;
        m_redir = 1'b1;
        m_rpc   = targetAddress;
        blocked = FLUSH_CYCLES;
      end
    end
  endtask

  task automatic check_all();
    chk("rfWrite", rfWrite, m_rf);          chk("rfAddr", rfAddr, m_rfa);
    chk("rfData", rfData, m_rfd);           chk("memWrite", memWrite, m_mw);
    chk("memAddr", memAddr, m_ma);          chk("memData", memData, m_md);
    chk("btbWrite", btbWrite, m_btb);       chk("btbPC", btbPC, m_bpc);
    chk("btbTarget", btbTarget, m_btgt);    chk("btbState", btbState, m_bst);
    chk("phtUpdate", phtUpdate, m_pht);     chk("phtIndex", phtIndex, m_pidx);
    chk("phtTaken", phtTaken, m_ptaken);    chk("cpuReset", cpuReset, m_cpu);
    chk("priorCommit", priorCommit, m_cpu); chk("reset_ptr", reset_ptr, m_rptr);
    chk("statusRestore", statusRestore, m_sr);
    chk("statusOut", statusOut, m_sout);    chk("redirect", redirect, m_redir);
    chk("redirectPC", redirectPC, m_rpc);   chk("retired", retired, m_ret);
  endtask

  // Called just after a negedge: one clock edge, then compare at the next negedge.
  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  // Mid-cycle asynchronous reset; outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    #2 globalResetN = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    globalResetN = 1'b1;
  endtask

  task automatic drive(input logic v, input logic [2:0] rob, input logic [31:0] res,
                       input logic [31:0] dst, input logic [3:0] ci, input logic [5:0] cf,
                       input logic [31:0] tgt, input logic [31:0] snap);
    validCommit = v; commitRob = rob; result = res; destCommit = dst;
    commitInfo = ci; controlFlow = cf; targetAddress = tgt; statusSnap = snap;
    oldPC = 32'h1000 + {27'd0, rob, 2'b00}; previousIndex = {5'd0, rob};
  endtask

  initial begin
    globalResetN = 1'b1;
    drive(1'b0, 3'd0, 32'd0, 32'd0, 4'd0, 6'd0, 32'd0, 32'd0);
    model_reset();
    @(negedge clk);
    do_reset();

    // ALU write to r5, then a write to x0 which must not reach the regfile
    drive(1'b1, 3'd0, 32'h1234, 32'd5, 4'b1000, 6'd0, 32'd0, 32'd0);
    step();
    chk("lit_rfWrite", rfWrite, 32'd1); chk("lit_rfAddr", rfAddr, 32'd5);
    chk("lit_rfData", rfData, 32'h1234); chk("lit_retired1", retired, 32'd1);
    drive(1'b1, 3'd1, 32'h5555, 32'd0, 4'b1000, 6'd0, 32'd0, 32'd0);
    step();
    chk("lit_rd0", rfWrite, 32'd0); chk("lit_retired2", retired, 32'd2);

    // store release is a single-cycle pulse
    drive(1'b1, 3'd2, 32'hAB, 32'h100, 4'b0100, 6'd0, 32'd0, 32'd0);
    step();
    chk("lit_memWrite", memWrite, 32'd1); chk("lit_memAddr", memAddr, 32'h100);
    chk("lit_memData", memData, 32'hAB); chk("lit_store_rf", rfWrite, 32'd0);
    validCommit = 1'b0;
    step();
    chk("lit_memPulse", memWrite, 32'd0);

    // mispredicted branch on tag 6; the ROB keeps presenting entry 6
    drive(1'b1, 3'd6, 32'd0, 32'd0, 4'b0001, 6'b1_10_1_1_1, 32'h40, 32'hF0);
    step();
    chk("lit_cpuReset", cpuReset, 32'd1); chk("lit_prior", priorCommit, 32'd1);
    chk("lit_rptr", reset_ptr, 32'd6); chk("lit_sout", statusOut, 32'hF0);
    chk("lit_rpc", redirectPC, 32'h40); chk("lit_redir1", redirect, 32'd1);
    chk("lit_retired4", retired, 32'd4);
    step();
    chk("lit_cpuPulse", cpuReset, 32'd0); chk("lit_redir2", redirect, 32'd1);
    step();
    chk("lit_redirDrop", redirect, 32'd0); chk("lit_noDouble", retired, 32'd4);
    validCommit = 1'b0;
    step();

    // eight back-to-back commits, tags 0..7
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'(i), 32'(i * 3), 32'(i + 1), 4'b1000, 6'b1_01_1_0_0, 32'h200, 32'd0);
      step();
    end
    chk("lit_retired12", retired, 32'd12); chk("lit_noRecover", redirect, 32'd0);
    validCommit = 1'b0;
    step();

    // reset while flushing, then a normal commit
    drive(1'b1, 3'd7, 32'd0, 32'd0, 4'b0001, 6'b1_11_0_0_1, 32'h80, 32'h3C);
    step();
    chk("lit_tag7", reset_ptr, 32'd7);
    step();
    do_reset();
    chk("lit_rstRedir", redirect, 32'd0);
    drive(1'b1, 3'd3, 32'h77, 32'd9, 4'b1000, 6'd0, 32'd0, 32'd0);
    step();
    chk("lit_afterRst", retired, 32'd1); chk("lit_afterRstRf", rfWrite, 32'd1);

    // random traffic with occasional mid-cycle resets
    for (int n = 0; n < 600; n++) begin
      drive(1'($urandom_range(0, 3) != 0), 3'($urandom), $urandom,
            ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
            4'($urandom), 6'($urandom), $urandom, $urandom);
      oldPC = $urandom; previousIndex = 8'($urandom);
      if ($urandom_range(0, 149) == 0) do_reset();
      else step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
